masked_serial_summer: RTL and testbench

Serial, handshaked summing stage that consumes a block of `NUM_INPUT` signed samples together with the active-input mask and the grown output width produced by the bit-growth calculator. It adds only the masked-in samples, one term per clock, into a full-precision accumulator. It then presents the sum, the width tag and a range-check flag to the downstream stage. It trades throughput for area compared with a parallel adder tree, and is used where blocks arrive sparsely.

---
 rtl/masked_serial_summer.sv | 153 +++++++++++++++
 tb/tb_masked_serial_summer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/masked_serial_summer.sv
// masked_serial_summer: serial handshaked summing stage. It adds the masked-in
// lanes of a captured block one term per clock into a full-precision accumulator.
// It then presents the sum, the width tag, the term count and a range-check flag.
module masked_serial_summer #(
    parameter  int NUM_INPUT = 8,
    parameter  int ORI_WIDTH = 16,
    localparam int ACC_W     = ORI_WIDTH + $clog2(NUM_INPUT)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_INPUT*ORI_WIDTH-1:0]  in_data,
    input  logic [NUM_INPUT-1:0]            ctr_in,
    input  logic [7:0]                      width_in,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [ACC_W-1:0]         sum,
    output logic [7:0]                      width_out,
    output logic [7:0]                      n_terms,
    output logic                            range_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [NUM_INPUT*ORI_WIDTH-1:0] data_reg;
    logic [NUM_INPUT-1:0]           mask_reg;
    logic [NUM_INPUT-1:0]           mask_rest;
    logic [7:0]                     width_reg;
    logic [7:0]                     term_cnt;
    logic signed [ACC_W-1:0]        acc;
    logic signed [ACC_W-1:0]        acc_next;
    logic signed [ORI_WIDTH-1:0]    sel_lane;
    logic signed [ACC_W-1:0]        lane_ext;
    logic signed [ACC_W-1:0]        shifted;
    logic [7:0]                     eff_w;
    logic                           range_reg;
    logic                           range_next;
    logic                           accept;
    logic                           last_term;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // Clearing the lowest set bit leaves the lanes still to be summed; when
    // nothing remains afterwards this edge is the final ACCUM edge.
    assign mask_rest = mask_reg & (mask_reg - NUM_INPUT'(1));
    assign last_term = (mask_rest == '0);

    // Pick the lowest-numbered remaining lane; scanning downward lets the
    // lowest set bit be the last assignment to win.
    always_comb begin
        sel_lane = '0;
        for (int i = NUM_INPUT - 1; i >= 0; i--) begin
            if (mask_reg[i]) begin
                sel_lane = data_reg[i*ORI_WIDTH +: ORI_WIDTH];
            end
        end
    end

    // Sign-extend the chosen lane and form the accumulator value for this edge.
    always_comb begin
        lane_ext = ACC_W'(sel_lane);
        acc_next = acc;
        if (mask_reg != '0) begin
            acc_next = acc + lane_ext;
        end
    end

    // Range check: the value fits in a signed field of w bits exactly when
    // everything above bit w-1 is a copy of the sign bit.
    always_comb begin
        eff_w = width_reg;
        if (width_reg == 8'd0) begin
            eff_w = 8'd1;
        end else if (width_reg > 8'(ACC_W)) begin
            eff_w = 8'(ACC_W);
        end
        shifted    = acc_next >>> (eff_w - 8'd1);
        range_next = !((shifted == '0) || (shifted == '1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the accept / accumulate / hold sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = ACCUM;
            ACCUM:   if (last_term) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: capture on accept, accumulate one term per edge, hold in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            mask_reg  <= '0;
            width_reg <= '0;
            term_cnt  <= '0;
            acc       <= '0;
            range_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_reg  <= in_data;
                        mask_reg  <= ctr_in;
                        width_reg <= width_in;
                        term_cnt  <= '0;
                        acc       <= '0;
                        range_reg <= 1'b0;
                    end
                end
                ACCUM: begin
                    acc      <= acc_next;
                    mask_reg <= mask_rest;
                    if (mask_reg != '0) begin
                        term_cnt <= term_cnt + 8'd1;
                    end
                    if (last_term) begin
                        range_reg <= range_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum       = acc;
    assign width_out = width_reg;
    assign n_terms   = term_cnt;
    assign range_err = range_reg;

endmodule

// File: tb/tb_masked_serial_summer.sv
// tb_masked_serial_summer: directed and randomized checks of masked_serial_summer
// against an arithmetic reference model of the masked sum and range rule.
module tb_masked_serial_summer;

    localparam int NI = 8;
    localparam int OW = 16;
    localparam int AW = OW + $clog2(NI);

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [NI*OW-1:0]       in_data;
    logic [NI-1:0]          ctr_in;
    logic [7:0]             width_in;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [AW-1:0]   sum;
    logic [7:0]             width_out;
    logic [7:0]             n_terms;
    logic                   range_err;

    int n_cmp;
    int n_fail;

    masked_serial_summer #(.NUM_INPUT(NI), .ORI_WIDTH(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ctr_in    (ctr_in),
        .width_in  (width_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .width_out (width_out),
        .n_terms   (n_terms),
        .range_err (range_err)
    );

    // Free-running clock, posedge at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain sum of the selected lanes.
    function automatic longint ref_sum(input logic [NI*OW-1:0] d, input logic [NI-1:0] m);
        longint s = 0;
        for (int i = 0; i < NI; i++) begin
            if (m[i]) s += longint'($signed(d[i*OW +: OW]));
        end
        return s;
    endfunction

    function automatic int ref_count(input logic [NI-1:0] m);
        int c = 0;
        for (int i = 0; i < NI; i++) c += int'(m[i]);
        return c;
    endfunction

    function automatic logic ref_range(input longint s, input int width);
        int w = width;
        longint lo, hi;
        if (w < 1) w = 1;
        if (w > AW) w = AW;
        lo = -(longint'(1) <<< (w - 1));
        hi = (longint'(1) <<< (w - 1)) - 1;
        return (s < lo) || (s > hi);
    endfunction

    function automatic logic [NI*OW-1:0] pack_lanes(input int v0, v1, v2, v3, v4, v5, v6, v7);
        logic [NI*OW-1:0] d;
        int v [8];
        v = '{v0, v1, v2, v3, v4, v5, v6, v7};
        for (int i = 0; i < NI; i++) d[i*OW +: OW] = OW'(v[i]);
        return d;
    endfunction

    function automatic logic [NI*OW-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer a block, let it be accepted, scramble the input bus, and count edges
    // until out_valid. Leaves the caller at a negedge with the DUT in DONE.
    task automatic start_block(input logic [NI*OW-1:0] d, input logic [NI-1:0] m,
                               input logic [7:0] w, output int lat);
        int waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        in_valid = 1'b1;
        in_data  = d;
        ctr_in   = m;
        width_in = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = rand_data();
        ctr_in   = NI'($urandom);
        width_in = 8'($urandom);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // Run one block to completion and return what the DUT presented.
    task automatic do_block(input logic [NI*OW-1:0] d, input logic [NI-1:0] m,
                            input logic [7:0] w, output int lat,
                            output longint s, output int nt, output int wo, output logic re);
        start_block(d, m, w, lat);
        s  = longint'(sum);
        nt = int'(n_terms);
        wo = int'(width_out);
        re = range_err;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({in_ready, out_valid} !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL reset_handshake: in_ready=%b out_valid=%b expected 0 0", in_ready, out_valid);
            end
            n_cmp++;
            if ({sum, width_out, n_terms, range_err} !== '0) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs: sum=%0d width_out=%0d n_terms=%0d range_err=%b expected all 0",
                         sum, width_out, n_terms, range_err);
            end
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_release_ready: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_full_mask();
        int lat, nt, wo;
        longint s;
        logic re;
        do_block(pack_lanes(1, -2, 3, -4, 5, -6, 7, -8), 8'hFF, 8'd19, lat, s, nt, wo, re);
        n_cmp++;
        if (lat !== 8) begin n_fail++; $display("[TB] FAIL full_latency: got %0d expected 8", lat); end
        n_cmp++;
        if (s !== -4) begin n_fail++; $display("[TB] FAIL full_sum: got %0d expected -4", s); end
        n_cmp++;
        if (nt !== 8) begin n_fail++; $display("[TB] FAIL full_nterms: got %0d expected 8", nt); end
        n_cmp++;
        if (wo !== 19 || re !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_width_range: width_out=%0d range_err=%b expected 19 0", wo, re);
        end
    endtask

    task automatic test_sparse_empty();
        int lat, nt, wo;
        longint s;
        logic re;
        do_block(pack_lanes(-32768, 11, 22, 33, 44, 55, 66, -32768), 8'h81, 8'd17, lat, s, nt, wo, re);
        n_cmp++;
        if (s !== -65536 || nt !== 2 || lat !== 2 || re !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL sparse: sum=%0d n_terms=%0d lat=%0d range_err=%b expected -65536 2 2 0", s, nt, lat, re);
        end
        do_block(rand_data(), 8'h00, 8'd5, lat, s, nt, wo, re);
        n_cmp++;
        if (s !== 0 || nt !== 0 || lat !== 1 || re !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL empty: sum=%0d n_terms=%0d lat=%0d range_err=%b expected 0 0 1 0", s, nt, lat, re);
        end
    endtask

    task automatic test_range();
        int lat, nt, wo;
        longint s;
        logic re;
        logic [NI*OW-1:0] d;
        d = pack_lanes(32767, 32767, -1, -1, -1, -1, -1, -1);
        do_block(d, 8'h03, 8'd16, lat, s, nt, wo, re);
        n_cmp++;
        if (s !== 65534 || re !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL range_w16: sum=%0d range_err=%b expected 65534 1", s, re);
        end
        do_block(d, 8'h03, 8'd17, lat, s, nt, wo, re);
        n_cmp++;
        if (s !== 65534 || re !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL range_w17: sum=%0d range_err=%b expected 65534 0", s, re);
        end
    endtask

    task automatic test_random();
        int lat, nt, wo, k;
        longint s, exp_s;
        logic re;
        logic [NI*OW-1:0] d;
        logic [NI-1:0] m;
        logic [7:0] w;
        for (int t = 0; t < 40; t++) begin
            d = rand_data();
            m = ($urandom_range(0, 7) == 0) ? NI'(0) : NI'($urandom);
            w = 8'($urandom_range(0, 26));
            exp_s = ref_sum(d, m);
            k = (ref_count(m) > 1) ? ref_count(m) : 1;
            do_block(d, m, w, lat, s, nt, wo, re);
            n_cmp++;
            if (s !== exp_s || nt !== ref_count(m) || wo !== int'(w) || re !== ref_range(exp_s, int'(w)) || lat !== k) begin
                n_fail++;
                $display("[TB] FAIL random[%0d] mask=%h w=%0d: sum=%0d nt=%0d wo=%0d re=%b lat=%0d expected %0d %0d %0d %b %0d",
                         t, m, w, s, nt, wo, re, lat, exp_s, ref_count(m), w, ref_range(exp_s, int'(w)), k);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        longint exp_s;
        logic [NI*OW-1:0] d;
        logic [NI*OW-1:0] d2;
        logic stable_ok;
        d = rand_data();
        exp_s = ref_sum(d, 8'h5A);
        start_block(d, 8'h5A, 8'd18, lat);
        stable_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || longint'(sum) !== exp_s || n_terms !== 8'd4 ||
                width_out !== 8'd18 || range_err !== ref_range(exp_s, 18)) begin
                stable_ok = 1'b0;
            end
            in_valid = 1'($urandom);
            in_data  = rand_data();
            ctr_in   = NI'($urandom);
            @(negedge clk);
        end
        n_cmp++;
        if (stable_ok !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL backpressure_hold: outputs changed or in_ready rose (sum=%0d expected %0d)", sum, exp_s);
        end
        d2 = rand_data();
        in_valid  = 1'b1;
        in_data   = d2;
        ctr_in    = 8'h0C;
        width_in  = 8'd20;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL handshake_idle: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = rand_data();
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        n_cmp++;
        if (lat !== 2 || longint'(sum) !== ref_sum(d2, 8'h0C) || n_terms !== 8'd2) begin
            n_fail++;
            $display("[TB] FAIL next_block: lat=%0d sum=%0d n_terms=%0d expected 2 %0d 2", lat, sum, n_terms, ref_sum(d2, 8'h0C));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int gap, seen, k, waits;
        longint exp_s;
        logic [NI*OW-1:0] d;
        logic [NI-1:0] m;
        out_ready = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        for (int b = 0; b < 4; b++) begin
            d = rand_data();
            m = NI'($urandom);
            exp_s = ref_sum(d, m);
            k = (ref_count(m) > 1) ? ref_count(m) : 1;
            in_valid = 1'b1;
            in_data  = d;
            ctr_in   = m;
            width_in = 8'd19;
            gap  = 0;
            seen = 0;
            do begin
                @(negedge clk);
                gap++;
                if (out_valid) begin
                    seen++;
                    n_cmp++;
                    if (longint'(sum) !== exp_s || int'(n_terms) !== ref_count(m)) begin
                        n_fail++;
                        $display("[TB] FAIL b2b_result[%0d]: sum=%0d n_terms=%0d expected %0d %0d", b, sum, n_terms, exp_s, ref_count(m));
                    end
                end
            end while (!in_ready && gap < 100);
            n_cmp++;
            if (gap !== k + 2 || seen !== 1) begin
                n_fail++;
                $display("[TB] FAIL b2b_interval[%0d]: interval=%0d pulses=%0d expected %0d 1", b, gap, seen, k + 2);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_accum();
        int lat, nt, wo, waits;
        longint s;
        logic re;
        logic pulse;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        in_valid  = 1'b1;
        in_data   = rand_data();
        ctr_in    = 8'hFF;
        width_in  = 8'd19;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || n_terms !== 8'd0 || width_out !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_state: in_ready=%b out_valid=%b sum=%0d n_terms=%0d width_out=%0d expected 1 0 0 0 0",
                     in_ready, out_valid, sum, n_terms, width_out);
        end
        pulse = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) pulse = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (pulse !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_pulse: out_valid seen=%b expected 0", pulse);
        end
        out_ready = 1'b0;
        do_block(pack_lanes(5, 100, 200, 300, 400, 500, 600, 700), 8'h01, 8'd8, lat, s, nt, wo, re);
        n_cmp++;
        if (s !== 5 || nt !== 1 || lat !== 1) begin
            n_fail++;
            $display("[TB] FAIL after_reset_block: sum=%0d n_terms=%0d lat=%0d expected 5 1 1", s, nt, lat);
        end
    endtask

    // Run every scenario in order and report the totals.
    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        ctr_in    = '0;
        width_in  = '0;
        out_ready = 1'b0;
        test_reset();
        test_full_mask();
        test_sparse_empty();
        test_range();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_accum();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
